// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt controller.
// Included by the resolver and the in-service control block.
package pic_pkg;

   localparam int IR_COUNT = 8;
   localparam int LVL_W    = 3;
   localparam int BASE_W   = 5;
   localparam int VEC_W    = 8;

   typedef enum logic [1:0] {
      IDLE,
      ACK1,
      ACK2,
      WAIT_END
   } ack_state_t;

   // 0 is the highest rank under the current rotation.
   function automatic logic [LVL_W-1:0] pri_rank(
      input logic [LVL_W-1:0] lvl,
      input logic [LVL_W-1:0] low
   );
      return lvl - low - 3'd1;
   endfunction

endpackage

// File: rtl/priority_resolver.sv
// Rotating priority search: scans from lowest_pri+1 upward,
// wrapping, and reports the first set request bit.
module priority_resolver
   import pic_pkg::*;
(
   input  logic [IR_COUNT-1:0] req,
   input  logic [LVL_W-1:0]    lowest_pri,
   output logic [LVL_W-1:0]    level,
   output logic                valid
);

   always_comb begin
      level = '0;
      valid = 1'b0;
      for (int i = 1; i <= IR_COUNT; i++) begin
         if (!valid && req[lowest_pri + LVL_W'(i)]) begin
            valid = 1'b1;
            level = lowest_pri + LVL_W'(i);
         end
      end
   end

endmodule

// File: rtl/in_service_control.sv
// In-service register, INTA sequencing and EOI handling
// for an 8259-style interrupt controller.
module in_service_control
   import pic_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic [IR_COUNT-1:0] Interrupt_Request_Reg,
   input  logic [IR_COUNT-1:0] Interrupt_Mask_Reg,
   input  logic [BASE_W-1:0]   Vector_Base,
   input  logic                AEOI_Mode,
   input  logic                INTA_n,
   input  logic                EOI_Strobe,
   input  logic                EOI_Specific,
   input  logic [LVL_W-1:0]    EOI_Level,
   input  logic                EOI_Rotate,
   output logic                INT,
   output logic [IR_COUNT-1:0] In_Service_Reg,
   output logic [IR_COUNT-1:0] Clear_IRR,
   output logic [VEC_W-1:0]    Data_Out,
   output logic                Data_Out_En
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   inta_d;
   logic                   fall;
   logic                   rise;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sync_q <= '1;
         inta_d <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], INTA_n};
         inta_d <= sync_q[SYNC_STAGES-1];
      end
   end

   assign fall = inta_d & ~sync_q[SYNC_STAGES-1];
   assign rise = ~inta_d & sync_q[SYNC_STAGES-1];

   logic [IR_COUNT-1:0] isr_q;
   logic [IR_COUNT-1:0] isr_nxt;
   logic [IR_COUNT-1:0] cand;
   logic [LVL_W-1:0]    cand_lvl;
   logic                cand_vld;
   logic [LVL_W-1:0]    isr_lvl;
   logic                isr_vld;
   logic [LVL_W-1:0]    lowest_pri;
   logic [LVL_W-1:0]    lvl_q;
   logic                spur_q;

   assign cand = Interrupt_Request_Reg & ~Interrupt_Mask_Reg;

   priority_resolver u_req_pri (
      .req        (cand),
      .lowest_pri (lowest_pri),
      .level      (cand_lvl),
      .valid      (cand_vld)
   );

   priority_resolver u_isr_pri (
      .req        (isr_q),
      .lowest_pri (lowest_pri),
      .level      (isr_lvl),
      .valid      (isr_vld)
   );

   ack_state_t state;
   ack_state_t state_nxt;
   logic       ack_go;
   logic       vec_go;
   logic       end_go;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ack_go    = 1'b0;
      vec_go    = 1'b0;
      end_go    = 1'b0;
      unique case (state)
         IDLE: if (fall) begin
            ack_go    = 1'b1;
            state_nxt = ACK1;
         end
         ACK1: if (rise) state_nxt = ACK2;
         ACK2: if (fall) begin
            vec_go    = 1'b1;
            state_nxt = WAIT_END;
         end
         WAIT_END: if (rise) begin
            end_go    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   logic             int_cond;
   logic             eoi_hit;
   logic [LVL_W-1:0] eoi_lvl;

   assign int_cond = cand_vld &&
      (!isr_vld ||
       pri_rank(cand_lvl, lowest_pri) < pri_rank(isr_lvl, lowest_pri));

   // Clears are applied before the set so a same-cycle set wins.
   always_comb begin
      isr_nxt = isr_q;
      eoi_hit = 1'b0;
      eoi_lvl = isr_lvl;
      if (EOI_Strobe) begin
         if (EOI_Specific) eoi_lvl = EOI_Level;
         eoi_hit = EOI_Specific ? isr_q[EOI_Level] : isr_vld;
         if (eoi_hit) isr_nxt[eoi_lvl] = 1'b0;
      end
      if (end_go && AEOI_Mode && !spur_q) isr_nxt[lvl_q] = 1'b0;
      if (ack_go && cand_vld) isr_nxt[cand_lvl] = 1'b1;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         isr_q       <= '0;
         INT         <= 1'b0;
         Clear_IRR   <= '0;
         Data_Out    <= '0;
         Data_Out_En <= 1'b0;
         lowest_pri  <= 3'd7;
         lvl_q       <= '0;
         spur_q      <= 1'b0;
      end else begin
         isr_q     <= isr_nxt;
         INT       <= (state == IDLE) && !ack_go && int_cond;
         Clear_IRR <= '0;
         if (EOI_Strobe && EOI_Rotate && eoi_hit) lowest_pri <= eoi_lvl;
         if (ack_go) begin
            lvl_q  <= cand_vld ? cand_lvl : 3'd7;
            spur_q <= !cand_vld;
            if (cand_vld)
               Clear_IRR <= {{(IR_COUNT-1){1'b0}}, 1'b1} << cand_lvl;
         end
         if (vec_go) begin
            Data_Out    <= {Vector_Base, lvl_q};
            Data_Out_En <= 1'b1;
         end
         if (end_go) begin
            Data_Out    <= '0;
            Data_Out_En <= 1'b0;
         end
      end
   end

   assign In_Service_Reg = isr_q;

endmodule

// File: tb/tb_in_service_control.sv
// Directed bench for in_service_control with a vector
// scoreboard and a Clear_IRR pulse monitor.
module tb_in_service_control;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic [7:0] Interrupt_Request_Reg = '0;
   logic [7:0] Interrupt_Mask_Reg = '0;
   logic [4:0] Vector_Base = 5'h08;
   logic       AEOI_Mode = 1'b0;
   logic       INTA_n = 1'b1;
   logic       EOI_Strobe = 1'b0;
   logic       EOI_Specific = 1'b0;
   logic [2:0] EOI_Level = '0;
   logic       EOI_Rotate = 1'b0;
   logic       INT;
   logic [7:0] In_Service_Reg;
   logic [7:0] Clear_IRR;
   logic [7:0] Data_Out;
   logic       Data_Out_En;

   int checks = 0;
   int errors = 0;
   int clr_cnt = 0;
   logic [7:0] clr_last = '0;
   logic [7:0] exp_q[$];

   in_service_control #(.SYNC_STAGES(2)) dut (
      .Clk                   (Clk),
      .Reset_n               (Reset_n),
      .Interrupt_Request_Reg (Interrupt_Request_Reg),
      .Interrupt_Mask_Reg    (Interrupt_Mask_Reg),
      .Vector_Base           (Vector_Base),
      .AEOI_Mode             (AEOI_Mode),
      .INTA_n                (INTA_n),
      .EOI_Strobe            (EOI_Strobe),
      .EOI_Specific          (EOI_Specific),
      .EOI_Level             (EOI_Level),
      .EOI_Rotate            (EOI_Rotate),
      .INT                   (INT),
      .In_Service_Reg        (In_Service_Reg),
      .Clear_IRR             (Clear_IRR),
      .Data_Out              (Data_Out),
      .Data_Out_En           (Data_Out_En)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (Clear_IRR != 8'h00) begin
         clr_cnt++;
         clr_last = Clear_IRR;
      end
   end

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      INTA_n  = 1'b1;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      repeat (2) @(negedge Clk);
   endtask

   task automatic inta_fall();
      INTA_n = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic inta_rise();
      INTA_n = 1'b1;
      repeat (4) @(negedge Clk);
   endtask

   task automatic wait_int(input string tag, input logic exp);
      int n = 0;
      while (INT !== exp && n < 10) begin
         @(negedge Clk);
         n++;
      end
      chk(tag, {7'd0, INT}, {7'd0, exp});
   endtask

   task automatic check_vec(input string tag);
      logic [7:0] e;
      int n = 0;
      while (!Data_Out_En && n < 10) begin
         @(negedge Clk);
         n++;
      end
      chk({tag, "_en"}, {7'd0, Data_Out_En}, 8'h01);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 8'h01, 8'h00);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_vec"}, Data_Out, e);
      end
   endtask

   task automatic eoi(input logic spec, input logic [2:0] lvl,
                      input logic rot);
      EOI_Strobe   = 1'b1;
      EOI_Specific = spec;
      EOI_Level    = lvl;
      EOI_Rotate   = rot;
      @(negedge Clk);
      EOI_Strobe   = 1'b0;
      EOI_Rotate   = 1'b0;
      @(negedge Clk);
   endtask

   initial begin
      repeat (2) @(negedge Clk);
      chk("rst_int", {7'd0, INT}, 8'h00);
      chk("rst_isr", In_Service_Reg, 8'h00);
      chk("rst_clr", Clear_IRR, 8'h00);
      chk("rst_dout", Data_Out, 8'h00);
      chk("rst_en", {7'd0, Data_Out_En}, 8'h00);
      Reset_n = 1'b1;
      repeat (2) @(negedge Clk);

      // Basic acknowledge of IR0 over IR7
      Interrupt_Request_Reg = 8'h81;
      wait_int("s1_int", 1'b1);
      clr_cnt = 0;
      exp_q.push_back(8'h40);
      inta_fall();
      chk("s1_isr", In_Service_Reg, 8'h01);
      chk("s1_int_low", {7'd0, INT}, 8'h00);
      Interrupt_Request_Reg = 8'h80;
      inta_rise();
      inta_fall();
      check_vec("s1");
      inta_rise();
      chk("s1_en_off", {7'd0, Data_Out_En}, 8'h00);
      chk("s1_dout_off", Data_Out, 8'h00);
      chk("s1_clr_cnt", 8'(clr_cnt), 8'h01);
      chk("s1_clr_val", clr_last, 8'h01);

      // Fully nested blocking and preemption
      do_reset();
      Interrupt_Request_Reg = 8'h04;
      wait_int("s2_int_a", 1'b1);
      exp_q.push_back(8'h42);
      inta_fall();
      Interrupt_Request_Reg = 8'h00;
      inta_rise();
      inta_fall();
      check_vec("s2a");
      inta_rise();
      chk("s2_isr_a", In_Service_Reg, 8'h04);
      Interrupt_Request_Reg = 8'h08;
      repeat (5) @(negedge Clk);
      chk("s2_int_blocked", {7'd0, INT}, 8'h00);
      Interrupt_Request_Reg = 8'h02;
      wait_int("s2_int_b", 1'b1);
      exp_q.push_back(8'h41);
      inta_fall();
      Interrupt_Request_Reg = 8'h00;
      inta_rise();
      inta_fall();
      check_vec("s2b");
      inta_rise();
      chk("s2_isr_b", In_Service_Reg, 8'h06);

      // Spurious: request withdrawn before INTA
      do_reset();
      Interrupt_Request_Reg = 8'h10;
      wait_int("s3_int", 1'b1);
      Interrupt_Request_Reg = 8'h00;
      clr_cnt = 0;
      exp_q.push_back(8'h47);
      inta_fall();
      inta_rise();
      inta_fall();
      check_vec("s3");
      inta_rise();
      chk("s3_isr", In_Service_Reg, 8'h00);
      chk("s3_clr_cnt", 8'(clr_cnt), 8'h00);

      // Automatic EOI on IR3
      do_reset();
      AEOI_Mode = 1'b1;
      Interrupt_Request_Reg = 8'h08;
      wait_int("s4_int", 1'b1);
      exp_q.push_back(8'h43);
      inta_fall();
      chk("s4_isr_set", In_Service_Reg, 8'h08);
      Interrupt_Request_Reg = 8'h00;
      inta_rise();
      inta_fall();
      check_vec("s4");
      chk("s4_isr_hold", In_Service_Reg, 8'h08);
      inta_rise();
      chk("s4_isr_clr", In_Service_Reg, 8'h00);
      AEOI_Mode = 1'b0;

      // Rotate on non-specific EOI, then specific EOI
      do_reset();
      Interrupt_Request_Reg = 8'h21;
      wait_int("s5_int", 1'b1);
      exp_q.push_back(8'h40);
      inta_fall();
      Interrupt_Request_Reg = 8'h20;
      inta_rise();
      inta_fall();
      check_vec("s5a");
      inta_rise();
      exp_q.push_back(8'h45);
      inta_fall();
      Interrupt_Request_Reg = 8'h00;
      inta_rise();
      inta_fall();
      check_vec("s5b");
      inta_rise();
      chk("s5_isr_21", In_Service_Reg, 8'h21);
      eoi(1'b0, 3'd0, 1'b1);
      chk("s5_isr_eoi", In_Service_Reg, 8'h20);
      Interrupt_Request_Reg = 8'h03;
      wait_int("s5_int_rot", 1'b1);
      exp_q.push_back(8'h41);
      inta_fall();
      Interrupt_Request_Reg = 8'h01;
      inta_rise();
      inta_fall();
      check_vec("s5c");
      inta_rise();
      chk("s5_isr_22", In_Service_Reg, 8'h22);
      eoi(1'b1, 3'd5, 1'b0);
      chk("s5_isr_spec", In_Service_Reg, 8'h02);

      // Reset in the middle of the acknowledge
      do_reset();
      Interrupt_Request_Reg = 8'h01;
      wait_int("s6_int", 1'b1);
      inta_fall();
      inta_rise();
      Reset_n = 1'b0;
      @(negedge Clk);
      chk("s6_rst_int", {7'd0, INT}, 8'h00);
      chk("s6_rst_isr", In_Service_Reg, 8'h00);
      chk("s6_rst_clr", Clear_IRR, 8'h00);
      chk("s6_rst_dout", Data_Out, 8'h00);
      chk("s6_rst_en", {7'd0, Data_Out_En}, 8'h00);
      Reset_n = 1'b1;
      repeat (4) @(negedge Clk);
      chk("s6_no_vec", {7'd0, Data_Out_En}, 8'h00);
      wait_int("s6_int_again", 1'b1);
      exp_q.push_back(8'h40);
      inta_fall();
      Interrupt_Request_Reg = 8'h00;
      inta_rise();
      inta_fall();
      check_vec("s6");
      inta_rise();
      chk("s6_isr", In_Service_Reg, 8'h01);
      chk("sb_drained", 8'(exp_q.size()), 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
